// File: rtl/soc_debug_ctrl.sv
// AXI4-Lite debug/control slave for the rv32i core: run/stop/N-step control, PC breakpoints,
// byte-strobed and fault-injected register-file writes, and a halt-event pulse.
module soc_debug_ctrl #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_BP         = 4,
  parameter int STEP_CNT_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  output logic                      pc_stall,
  input  logic [DATA_WIDTH-1:0]     pc_read_data,
  output logic                      pc_write_enable,
  output logic [DATA_WIDTH-1:0]     pc_write_data,
  output logic [REG_ADDR_WIDTH-1:0] regfile_addr,
  input  logic [DATA_WIDTH-1:0]     regfile_read_data,
  output logic                      regfile_write_enable,
  output logic [DATA_WIDTH-1:0]     regfile_write_data,
  output logic                      halt_event,
  input  logic [AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                S_AXI_AWPROT,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                S_AXI_ARPROT,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int RF_SPAN = 2 << REG_ADDR_WIDTH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_RESP, WR_ADDR, WR_DATA, WR_RMW, WR_COMMIT, WR_RESP
  } state_t;

  state_t                    state_q, state_d;
  logic                      active_q;
  logic [15:0]               addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d, old_q, old_d, rdata_q, rdata_d;
  logic [STRB_W-1:0]         strb_q, strb_d;
  logic [1:0]                rresp_q, rresp_d, bresp_q, bresp_d;
  logic                      stall_q, stall_d, skip_q, skip_d, bp_hit_q, bp_hit_d;
  logic                      halt_event_q, halt_event_d;
  logic [STEP_CNT_WIDTH-1:0] step_remain_q, step_remain_d, step_n;
  logic [4:0]                bp_index_q, bp_index_d, bp_idx;
  logic [NUM_BP-1:0]         bp_enable_q, bp_enable_d;
  logic [DATA_WIDTH-1:0]     fault_mask_q, fault_mask_d;
  logic [DATA_WIDTH-1:0]     bp_addr_q [NUM_BP];
  logic [DATA_WIDTH-1:0]     bp_addr_d [NUM_BP];

  logic [7:0]            sel, sub;
  logic                  is_ctrl, is_rf, is_bp, rf_fault, rf_x0;
  logic [STRB_W-1:0]     wstrb_eff;
  logic                  wr_err, rd_err, bp_any, bp_match;
  logic [DATA_WIDTH-1:0] rd_data, merged;
  logic                  unused_prot_addr;

  assign unused_prot_addr = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                              S_AXI_AWADDR[AXI_ADDR_WIDTH-1:16], S_AXI_ARADDR[AXI_ADDR_WIDTH-1:16]};

  assign sel      = addr_q[15:8];
  assign sub      = addr_q[7:0];
  assign is_ctrl  = (sel == 8'h01) && (sub < 8'h08);
  assign is_rf    = (sel == 8'h02) && (int'(sub) < RF_SPAN);
  assign is_bp    = (sel == 8'h03) && (int'(sub) < NUM_BP);
  assign rf_fault = sub[REG_ADDR_WIDTH];
  assign rf_x0    = (sub[REG_ADDR_WIDTH-1:0] == '0);
  assign step_n   = wdata_q[STEP_CNT_WIDTH-1:0];

  // While WDATA is being accepted the strobe is still on the bus, so the RMW decision uses it directly.
  assign wstrb_eff = (state_q == WR_DATA) ? S_AXI_WSTRB : strb_q;
  assign wr_err = !(is_ctrl || is_rf || is_bp)
                || (is_ctrl && (sub == 8'h00 || sub == 8'h05))
                || (is_rf && rf_x0)
                || ((is_ctrl || is_bp) && !(&wstrb_eff))
                || (is_rf && (wstrb_eff == '0));

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (is_ctrl) begin
      case (sub[2:0])
        3'd0: begin
          rd_data[12:8] = bp_index_q;
          rd_data[1]    = bp_hit_q;
          rd_data[0]    = stall_q;
        end
        3'd4:    rd_data = pc_read_data;
        3'd5:    rd_data[STEP_CNT_WIDTH-1:0] = step_remain_q;
        3'd6:    rd_data[NUM_BP-1:0] = bp_enable_q;
        3'd7:    rd_data = fault_mask_q;
        default: rd_data = '0;
      endcase
    end else if (is_rf) begin
      rd_data = regfile_read_data;
    end else if (is_bp) begin
      for (int i = 0; i < NUM_BP; i++)
        if (int'(sub) == i) rd_data = bp_addr_q[i];
    end else begin
      rd_err = 1'b1;
    end
  end

  always_comb begin
    merged = '0;
    for (int b = 0; b < STRB_W; b++)
      merged[8*b +: 8] = strb_q[b] ? wdata_q[8*b +: 8] : old_q[8*b +: 8];
    regfile_write_data = rf_fault ? (merged ^ fault_mask_q) : merged;
  end

  // Lowest enabled comparator wins; skip masks the first running cycle after START/STEP.
  always_comb begin
    bp_any = 1'b0;
    bp_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--)
      if (bp_enable_q[i] && (bp_addr_q[i] == pc_read_data)) begin
        bp_any = 1'b1;
        bp_idx = 5'(i);
      end
  end
  assign bp_match = !stall_q && !skip_q && bp_any;

  always_comb begin
    state_d              = state_q;
    addr_d               = addr_q;
    wdata_d              = wdata_q;
    strb_d               = strb_q;
    old_d                = old_q;
    rdata_d              = rdata_q;
    rresp_d              = rresp_q;
    bresp_d              = bresp_q;
    stall_d              = stall_q;
    skip_d               = skip_q;
    bp_hit_d             = bp_hit_q;
    bp_index_d           = bp_index_q;
    step_remain_d        = step_remain_q;
    bp_enable_d          = bp_enable_q;
    fault_mask_d         = fault_mask_q;
    bp_addr_d            = bp_addr_q;
    pc_write_enable      = 1'b0;
    regfile_write_enable = 1'b0;

    if (!stall_q) begin
      skip_d = 1'b0;
      if (step_remain_q != '0) begin
        step_remain_d = step_remain_q - 1'b1;
        if (step_remain_q == STEP_CNT_WIDTH'(1)) stall_d = 1'b1;
      end
    end
    if (bp_match) begin
      stall_d       = 1'b1;
      bp_hit_d      = 1'b1;
      bp_index_d    = bp_idx;
      step_remain_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (active_q && S_AXI_ARVALID) begin
          addr_d  = S_AXI_ARADDR[15:0];
          state_d = RD_ISSUE;
        end else if (active_q && S_AXI_AWVALID) begin
          state_d = WR_ADDR;
        end
      end
      RD_ISSUE: begin
        rdata_d = rd_data;
        rresp_d = rd_err ? RESP_SLVERR : RESP_OKAY;
        state_d = RD_RESP;
      end
      RD_RESP: if (S_AXI_RREADY) state_d = IDLE;
      WR_ADDR: begin
        if (S_AXI_AWVALID) begin
          addr_d  = S_AXI_AWADDR[15:0];
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (S_AXI_WVALID) begin
          wdata_d = S_AXI_WDATA;
          strb_d  = S_AXI_WSTRB;
          state_d = (!wr_err && is_rf && !(&S_AXI_WSTRB)) ? WR_RMW : WR_COMMIT;
        end
      end
      WR_RMW: begin
        old_d   = regfile_read_data;
        state_d = WR_COMMIT;
      end
      WR_COMMIT: begin
        bresp_d = wr_err ? RESP_SLVERR : RESP_OKAY;
        state_d = WR_RESP;
        if (!wr_err) begin
          if (is_rf) begin
            regfile_write_enable = 1'b1;
          end else if (is_bp) begin
            for (int i = 0; i < NUM_BP; i++)
              if (int'(sub) == i) bp_addr_d[i] = wdata_q;
          end else begin
            case (sub[2:0])
              3'd1: begin
                stall_d       = 1'b0;
                step_remain_d = '0;
                skip_d        = 1'b1;
                bp_hit_d      = 1'b0;
              end
              3'd2: begin
                stall_d       = 1'b1;
                step_remain_d = '0;
              end
              3'd3: begin
                stall_d       = 1'b0;
                step_remain_d = (step_n == '0) ? STEP_CNT_WIDTH'(1) : step_n;
                skip_d        = 1'b1;
                bp_hit_d      = 1'b0;
              end
              3'd4:    pc_write_enable = 1'b1;
              3'd6:    bp_enable_d = wdata_q[NUM_BP-1:0];
              3'd7:    fault_mask_d = wdata_q;
              default: ;
            endcase
          end
        end
      end
      WR_RESP: if (S_AXI_BREADY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign halt_event_d = !stall_q && stall_d;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q       <= IDLE;
      active_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      strb_q        <= '0;
      old_q         <= '0;
      rdata_q       <= '0;
      rresp_q       <= RESP_OKAY;
      bresp_q       <= RESP_OKAY;
      stall_q       <= 1'b1;
      skip_q        <= 1'b0;
      bp_hit_q      <= 1'b0;
      bp_index_q    <= '0;
      step_remain_q <= '0;
      bp_enable_q   <= '0;
      fault_mask_q  <= '0;
      halt_event_q  <= 1'b0;
      for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      active_q      <= 1'b1;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      strb_q        <= strb_d;
      old_q         <= old_d;
      rdata_q       <= rdata_d;
      rresp_q       <= rresp_d;
      bresp_q       <= bresp_d;
      stall_q       <= stall_d;
      skip_q        <= skip_d;
      bp_hit_q      <= bp_hit_d;
      bp_index_q    <= bp_index_d;
      step_remain_q <= step_remain_d;
      bp_enable_q   <= bp_enable_d;
      fault_mask_q  <= fault_mask_d;
      halt_event_q  <= halt_event_d;
      bp_addr_q     <= bp_addr_d;
    end
  end

  assign pc_stall      = stall_q | bp_match;
  assign pc_write_data = wdata_q;
  assign regfile_addr  = addr_q[REG_ADDR_WIDTH-1:0];
  assign halt_event    = halt_event_q;
  assign S_AXI_ARREADY = (state_q == IDLE) && active_q;
  assign S_AXI_AWREADY = (state_q == WR_ADDR);
  assign S_AXI_WREADY  = (state_q == WR_DATA);
  assign S_AXI_BVALID  = (state_q == WR_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = (state_q == RD_RESP);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule
